xoroshiro_prng_mc: RTL and testbench
====================================

Name: xoroshiro_prng_mc

Overview:
Multi-channel, parametrised successor to the single-stream xoroshiro128+ generator. It accepts a 128-bit seed through a valid/ready handshake and expands it into NUM_CH non-overlapping streams: channel k is channel k-1 advanced by 2^64 steps using the jump polynomial. It then delivers NUM_CH x 64-bit words per transfer on a backpressured output stream, with a scrambler selected at seed time (+, ++, **). It sits between the seed source (TRNG or CPU register) and the consumers of random words (noise/test-pattern engines).

Parameters:
NUM_CH, 2, number of independent 64-bit streams (1..8)
DEFAULT_S0, 64'h0123456789ABCDEF, substitute for s0 when a zero seed is loaded
DEFAULT_S1, 64'hFEDCBA9876543210, substitute for s1 when a zero seed is loaded

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
seed_valid  in  1  seed offered
seed_ready  out  1  block can accept a seed
seed_data  in  128  [127:64]=s0, [63:0]=s1
seed_mode  in  2  scrambler: 0 plus, 1 plusplus, 2 starstar, 3 reserved (treated as plus)
out_valid  out  1  out_data holds a valid word set
out_ready  in  1  consumer accepts out_data
out_data  out  64*NUM_CH  channel k at [64k+63:64k]
busy  out  1  jump expansion in progress

Behaviour:
- Only clock: clk. Reset: rst_n, asynchronous assert, synchronous deassert at the block boundary. rst_n low: FSM=UNSEEDED, out_valid=0, busy=0, seed_ready=0 while in reset, all state registers=0, mode=0. The block is unusable until a seed is loaded.
- State transition, per channel, applied on advance (xoroshiro128 a=24, b=16, c=37):
  - t=s1^s0
  - s0'=rotl(s0,24)^t^(t<<16)
  - s1'=rotl(t,37)
- Scramblers, combinational from current state, mod 2^64:
  - plus: s0+s1
  - plusplus: rotl(s0+s1,17)+s0
  - starstar: rotl(s0*5,7)*9
- FSM states: UNSEEDED, COPY, JUMP, RUN.
  - seed_ready=1 in UNSEEDED and RUN, 0 in COPY/JUMP.
- Seed accept (seed_valid&&seed_ready at edge T):
  - ch0 <= seed; if seed_data==0, ch0 <= {DEFAULT_S0, DEFAULT_S1}.
  - mode latched from seed_mode.
  - NUM_CH==1: go to RUN, out_valid=1 from T+1.
  - NUM_CH>1: go to COPY, out_valid=0 and busy=1 from T+1.
- COPY (1 cycle): work <= ch(k-1); accumulator <= 0; bit counter <= 0. Go to JUMP.
- JUMP (128 cycles, bit i=0..127 of {J1,J0}, J0=64'hDF900294D8F554A5 consumed LSB-first first, then J1=64'h170865DF4B3201FC):
  - if the bit is set, acc ^= work;
  - work advances every cycle.
  - At i=127, ch k <= final acc value (including that cycle's xor). k increments; go to COPY if k<NUM_CH, else RUN.
- Expansion cost: 129*(NUM_CH-1) cycles; out_valid rises at T+1+129*(NUM_CH-1).
- RUN:
  - out_valid=1.
  - out_valid&&out_ready advances all channels simultaneously; the next word appears the following cycle (throughput 1 per cycle).
  - out_ready=0 holds out_data and state unchanged.
- Seed accepted in RUN together with out_ready: the seed wins and no advance occurs. out_valid follows the seed-accept rules above.
- seed_valid during COPY/JUMP is ignored (seed_ready=0); expansion is never aborted except by rst_n.
- rst_n low mid-JUMP: immediate return to reset values; a partially expanded state is never exposed.
- out_data is undefined-but-stable (scramble of stored state) while out_valid=0; consumers must ignore it.

Test Plan:
- NUM_CH=1, mode=plus, seed s0=1, s1=2, out_ready=1:
  - out_valid at T+1.
  - Words: 64'h3, then 64'h6001030003.
- NUM_CH=1, seed 1/2:
  - mode=plusplus: first word 64'h60001.
  - mode=starstar: first word 64'h1680.
- Zero seed, mode=plus: first word 64'hFFFFFFFFFFFFFFFF (defaults substituted).
- NUM_CH=2, seed 1/2:
  - busy=1 and seed_ready=0 for exactly 129 cycles; out_valid at T+130.
  - ch0 word = 64'h3.
  - ch1 equals the C reference model's jump() of (1,2) scrambled.
  - A seed_valid pulse mid-jump is ignored.
- RUN with out_ready toggling 1,0,0,1:
  - out_data constant across the stalled cycles.
  - Exactly 2 advances observed vs. the golden sequence.
- Assert rst_n low at cycle 50 of JUMP:
  - outputs return to reset values asynchronously.
  - A fresh seed after release reproduces the scenario 4 results.

Source files
------------

// File: rtl/xoroshiro_prng_mc.sv
// Multi-channel xoroshiro128 generator (+, ++, **); channel k is channel k-1 jumped 2^64 steps.
// Latency: first word set 1 cycle after seed accept, plus 129 cycles per extra channel; then 1 set/cycle.
// Backpressure: out_ready low holds out_data and all channel state; seeds are refused during expansion.
module xoroshiro_prng_mc #(
  parameter int          NUM_CH     = 2,
  parameter logic [63:0] DEFAULT_S0 = 64'h0123456789ABCDEF,
  parameter logic [63:0] DEFAULT_S1 = 64'hFEDCBA9876543210
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seed_valid,
  output logic                 seed_ready,
  input  logic [127:0]         seed_data,
  input  logic [1:0]           seed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [64*NUM_CH-1:0] out_data,
  output logic                 busy
);

  typedef struct packed {
    logic [63:0] s0;
    logic [63:0] s1;
  } xo_state_t;

  typedef enum logic [1:0] {UNSEEDED, COPY, JUMP, RUN} fsm_t;

  localparam int IW = $clog2(NUM_CH + 1);
  // Jump polynomial, consumed LSB-first from the low word upwards.
  localparam logic [127:0] JUMP_POLY = {64'h170865DF4B3201FC, 64'hDF900294D8F554A5};

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  function automatic xo_state_t xo_next(input xo_state_t s);
    logic [63:0] t;
    xo_state_t   n;
    t    = s.s0 ^ s.s1;
    n.s0 = rotl64(s.s0, 24) ^ t ^ (t << 16);
    n.s1 = rotl64(t, 37);
    return n;
  endfunction

  function automatic logic [63:0] scramble(input xo_state_t s, input logic [1:0] m);
    logic [63:0] p;
    case (m)
      2'd1: p = rotl64(s.s0 + s.s1, 17) + s.s0;
      2'd2: begin
        p = s.s0 * 64'd5;
        p = rotl64(p, 7) * 64'd9;
      end
      default: p = s.s0 + s.s1;
    endcase
    return p;
  endfunction

  fsm_t        state, state_nxt;
  xo_state_t   ch [NUM_CH];
  xo_state_t   work, acc, acc_nxt, copy_src, seed_state;
  logic [6:0]  bit_cnt;
  logic [IW-1:0] ch_idx;
  logic [1:0]  mode;
  logic        seed_acc, adv, last_ch;

  assign seed_ready = rst_n && ((state == UNSEEDED) || (state == RUN));
  assign out_valid  = (state == RUN);
  assign busy       = (state == COPY) || (state == JUMP);
  assign seed_acc   = seed_valid && seed_ready;
  // A seed offered alongside a consumer accept takes priority; no advance that cycle.
  assign adv        = (state == RUN) && out_ready && !seed_acc;
  assign last_ch    = (ch_idx == IW'(NUM_CH - 1));

  always_comb begin
    seed_state = (seed_data == '0) ? {DEFAULT_S0, DEFAULT_S1} : seed_data;
    acc_nxt    = JUMP_POLY[bit_cnt] ? (acc ^ work) : acc;
    copy_src   = ch[0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (ch_idx == IW'(k)) copy_src = ch[k-1];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UNSEEDED, RUN: if (seed_acc) state_nxt = (NUM_CH == 1) ? RUN : COPY;
      COPY:          state_nxt = JUMP;
      JUMP:          if (bit_cnt == 7'd127) state_nxt = last_ch ? RUN : COPY;
      default:       state_nxt = UNSEEDED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNSEEDED;
      mode    <= 2'd0;
      work    <= '0;
      acc     <= '0;
      bit_cnt <= '0;
      ch_idx  <= '0;
      for (int k = 0; k < NUM_CH; k++) ch[k] <= '0;
    end else begin
      state <= state_nxt;
      if (seed_acc) begin
        mode   <= seed_mode;
        ch[0]  <= seed_state;
        ch_idx <= IW'(1);
      end else if (adv) begin
        for (int k = 0; k < NUM_CH; k++) ch[k] <= xo_next(ch[k]);
      end else if (state == COPY) begin
        work    <= copy_src;
        acc     <= '0;
        bit_cnt <= '0;
      end else if (state == JUMP) begin
        acc     <= acc_nxt;
        work    <= xo_next(work);
        bit_cnt <= bit_cnt + 7'd1;
        // Final bit: the result includes this cycle's conditional xor.
        if (bit_cnt == 7'd127) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (ch_idx == IW'(k)) ch[k] <= acc_nxt;
          end
          ch_idx <= ch_idx + IW'(1);
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_CH; k++) out_data[64*k +: 64] = scramble(ch[k], mode);
  end

endmodule

// File: tb/tb_xoroshiro_prng_mc.sv
// Scoreboard bench: one single-channel and one three-channel instance against a spec-level model.
module tb_xoroshiro_prng_mc;

  localparam int NB = 3;
  localparam logic [63:0] DEF0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] DEF1 = 64'hFEDCBA9876543210;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] sv = '0;
  logic [1:0] ordy = '0;
  logic [127:0] seed_data = '0;
  logic [1:0] seed_mode = '0;
  logic a_sr, a_ov, a_bz, b_sr, b_ov, b_bz;
  logic [63:0] a_od;
  logic [64*NB-1:0] b_od;
  logic [1:0] sr, ov, bz;
  logic [511:0] od [2];

  assign sr = {b_sr, a_sr};
  assign ov = {b_ov, a_ov};
  assign bz = {b_bz, a_bz};
  assign od[0] = 512'(a_od);
  assign od[1] = 512'(b_od);

  always #5 clk = ~clk;

  xoroshiro_prng_mc #(.NUM_CH(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .seed_valid(sv[0]), .seed_ready(a_sr),
    .seed_data(seed_data), .seed_mode(seed_mode), .out_valid(a_ov),
    .out_ready(ordy[0]), .out_data(a_od), .busy(a_bz));

  xoroshiro_prng_mc #(.NUM_CH(NB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .seed_valid(sv[1]), .seed_ready(b_sr),
    .seed_data(seed_data), .seed_mode(seed_mode), .out_valid(b_ov),
    .out_ready(ordy[1]), .out_data(b_od), .busy(b_bz));

  int checks = 0;
  int failures = 0;
  logic [127:0] mst [2][8];
  logic [1:0] mmode [2];
  int mnch [2];
  logic [511:0] q0 [$];
  logic [511:0] q1 [$];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: per-channel 128-bit state {s0,s1}.
  function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  function automatic logic [127:0] nxt(input logic [127:0] s);
    logic [63:0] a, b, t;
    a = s[127:64];
    b = s[63:0];
    t = a ^ b;
    return {rotl(a, 24) ^ t ^ (t << 16), rotl(t, 37)};
  endfunction

  function automatic logic [127:0] xjump(input logic [127:0] s);
    logic [63:0] jw [2];
    logic [127:0] acc, cur;
    jw[0] = 64'hDF900294D8F554A5;
    jw[1] = 64'h170865DF4B3201FC;
    acc = '0;
    cur = s;
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 64; b++) begin
        if (jw[w][b]) acc ^= cur;
        cur = nxt(cur);
      end
    end
    return acc;
  endfunction

  function automatic logic [63:0] scr(input logic [127:0] s, input logic [1:0] m);
    logic [63:0] a, b, p;
    a = s[127:64];
    b = s[63:0];
    case (m)
      2'd1: p = rotl(a + b, 17) + a;
      2'd2: begin
        p = a * 64'd5;
        p = rotl(p, 7) * 64'd9;
      end
      default: p = a + b;
    endcase
    return p;
  endfunction

  function automatic int qsz(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [511:0] qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic qclear(input int d);
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  task automatic model_seed(input int d, input logic [127:0] sd, input logic [1:0] md);
    mst[d][0] = (sd == '0) ? {DEF0, DEF1} : sd;
    for (int k = 1; k < mnch[d]; k++) mst[d][k] = xjump(mst[d][k-1]);
    mmode[d] = md;
  endtask

  task automatic model_push(input int d);
    logic [511:0] w;
    w = '0;
    for (int k = 0; k < mnch[d]; k++) begin
      w[64*k +: 64] = scr(mst[d][k], mmode[d]);
      mst[d][k] = nxt(mst[d][k]);
    end
    if (d == 0) q0.push_back(w); else q1.push_back(w);
  endtask

  // Monitor: whenever a word set is pending and out_valid is high, out_data must match it.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (ov[d] && qsz(d) > 0) chk((d == 0) ? "word_a" : "word_b", od[d], qfront(d));
        if (ov[d] && ordy[d] && !(sv[d] && sr[d])) begin
          if (qsz(d) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_xfer dut=%0d actual=%0h required=no transfer", d, od[d]);
          end else begin
            qpop(d);
          end
        end
      end
    end
  end

  task automatic do_seed(input int d, input logic [127:0] sd, input logic [1:0] md,
                         input logic rdy, input logic poke);
    int n, lat, bcnt, srlo;
    n = 0;
    while (!sr[d] && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("seed_rdy_wait", 512'(sr[d]), 512'(1));
    seed_data = sd;
    seed_mode = md;
    sv[d] = 1'b1;
    ordy[d] = rdy;
    @(posedge clk); #1;
    sv[d] = 1'b0;
    ordy[d] = 1'b0;
    seed_data = {$urandom, $urandom, $urandom, $urandom};
    seed_mode = 2'($urandom_range(0, 3));
    model_seed(d, sd, md);
    lat = 0; bcnt = 0; srlo = 0;
    while (!ov[d] && lat < 2000) begin
      if (bz[d]) bcnt++;
      if (!sr[d]) srlo++;
      if (poke && lat == 60) begin
        sv[d] = 1'b1;
        seed_data = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        sv[d] = 1'b0;
      end
      @(posedge clk); #1; lat++;
    end
    sv[d] = 1'b0;
    chk("valid_latency", 512'(lat), 512'(129 * (mnch[d] - 1)));
    chk("busy_cycles", 512'(bcnt), 512'(129 * (mnch[d] - 1)));
    chk("seed_rdy_low_cycles", 512'(srlo), 512'(129 * (mnch[d] - 1)));
    chk("run_busy", 512'(bz[d]), '0);
    chk("run_seed_rdy", 512'(sr[d]), 512'(1));
  endtask

  task automatic run_words(input int d, input int n, input int pct);
    int cyc;
    for (int i = 0; i < n; i++) model_push(d);
    cyc = 0;
    while (qsz(d) > 0 && cyc < 400) begin
      ordy[d] = ($urandom_range(0, 99) < pct);
      @(posedge clk); #1; cyc++;
    end
    ordy[d] = 1'b0;
    chk("drain", 512'(qsz(d)), '0);
    qclear(d);
  endtask

  task automatic run_pat(input int d, input logic [7:0] pat, input int len);
    for (int i = 0; i < len; i++) if (pat[i]) model_push(d);
    for (int i = 0; i < len; i++) begin
      ordy[d] = pat[i];
      @(posedge clk); #1;
    end
    ordy[d] = 1'b0;
    chk("pattern_advances", 512'(qsz(d)), '0);
    qclear(d);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    logic [127:0] sd;
    mnch[0] = 1;
    mnch[1] = NB;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", 512'(ov[i]), '0);
      chk("rst_busy", 512'(bz[i]), '0);
      chk("rst_seed_ready", 512'(sr[i]), '0);
    end
    rst_n = 1'b1;
    #1;
    chk("unseeded_rdy_a", 512'(sr[0]), 512'(1));
    chk("unseeded_valid_b", 512'(ov[1]), '0);

    // Single channel, seed 1/2, all three scramblers and the zero-seed substitution.
    do_seed(0, {64'd1, 64'd2}, 2'd0, 1'b0, 1'b0);
    chk("plus_w0", od[0], 512'(64'h3));
    run_words(0, 1, 100);
    chk("plus_w1", od[0], 512'(64'h6001030003));
    run_words(0, 4, 60);
    do_seed(0, {64'd1, 64'd2}, 2'd1, 1'b1, 1'b0);
    chk("plusplus_w0", od[0], 512'(64'h60001));
    run_words(0, 3, 70);
    do_seed(0, {64'd1, 64'd2}, 2'd2, 1'b1, 1'b0);
    chk("starstar_w0", od[0], 512'(64'h1680));
    run_words(0, 3, 70);
    do_seed(0, '0, 2'd0, 1'b0, 1'b0);
    chk("zero_seed_w0", od[0], 512'(64'hFFFFFFFFFFFFFFFF));
    run_words(0, 3, 50);
    do_seed(0, {$urandom, $urandom, $urandom, $urandom}, 2'd3, 1'b1, 1'b0);
    run_words(0, 4, 50);

    // Three channels with a seed pulse during expansion, then stalled reads.
    do_seed(1, {64'd1, 64'd2}, 2'd0, 1'b0, 1'b1);
    chk("multi_ch0_w0", 512'(od[1][63:0]), 512'(64'h3));
    run_words(1, 3, 100);
    run_pat(1, 8'b0000_1001, 4);
    run_words(1, 1, 100);

    // Reset asserted 50 cycles into the first jump.
    chk("pre_seed_rdy_b", 512'(sr[1]), 512'(1));
    seed_data = {64'd1, 64'd2};
    seed_mode = 2'd0;
    sv[1] = 1'b1;
    @(posedge clk); #1;
    sv[1] = 1'b0;
    repeat (51) @(posedge clk);
    #2;
    chk("mid_jump_busy", 512'(bz[1]), 512'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid_b", 512'(ov[1]), '0);
    chk("async_rst_busy_b", 512'(bz[1]), '0);
    chk("async_rst_rdy_b", 512'(sr[1]), '0);
    chk("async_rst_valid_a", 512'(ov[0]), '0);
    qclear(0);
    qclear(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy_b", 512'(sr[1]), 512'(1));
    chk("post_rst_valid_b", 512'(ov[1]), '0);
    do_seed(1, {64'd1, 64'd2}, 2'd0, 1'b0, 1'b0);
    chk("reseed_ch0_w0", 512'(od[1][63:0]), 512'(64'h3));
    run_words(1, 3, 100);

    // Randomized reseeds, scramblers and backpressure on both instances.
    for (int it = 0; it < 14; it++) begin
      d = int'($urandom_range(0, 1));
      sd = ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
      do_seed(d, sd, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      run_words(d, int'($urandom_range(1, 6)), int'($urandom_range(30, 100)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
